// File: rtl/spi_rx_frame_parser.sv
// Sync-hunting, length-prefixed, checksummed frame parser fed by the SPI master's byte stream.
// Optional statistics counters (good_cnt/bad_cnt) are built when SPI_RX_FRAME_STATS_EN is defined.
module spi_rx_frame_parser #(
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [7:0]  frame_len,
  output logic        err_csum,
  output logic        err_len,
  output logic        err_timeout,
  output logic        overrun,
  output logic        busy
`ifdef SPI_RX_FRAME_STATS_EN
  ,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
`endif
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned DEPTH = 1 << IDX_W;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LEN     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_CSUM    = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       csum_q, csum_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [15:0]      tmo_q, tmo_d;
  logic [7:0]       payload_q [DEPTH];
  logic [7:0]       payload_d [DEPTH];

  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       out_last_q, out_last_d;
  logic [7:0] frame_len_q, frame_len_d;
  logic       err_csum_q, err_csum_d;
  logic       err_len_q, err_len_d;
  logic       err_timeout_q, err_timeout_d;
  logic       overrun_q, overrun_d;
  logic       busy_q, busy_d;
  logic       in_frame;

  // Frame FSM, buffer write, timeout and registered output values
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    csum_d        = csum_q;
    wr_idx_d      = wr_idx_q;
    rd_idx_d      = rd_idx_q;
    payload_d     = payload_q;
    frame_len_d   = frame_len_q;
    err_csum_d    = 1'b0;
    err_len_d     = 1'b0;
    err_timeout_d = 1'b0;
    overrun_d     = 1'b0;
    in_frame      = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
    // Idle-cycle counter only advances while a frame is being collected
    tmo_d         = in_frame ? (tmo_q + 16'd1) : 16'd0;
    if (in_frame && rx_valid) begin
      tmo_d = 16'd0;
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_byte == SYNC_BYTE)) begin
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (rx_valid) begin
          len_d  = rx_byte;
          csum_d = rx_byte;
          if ((rx_byte == 8'd0) || (rx_byte > 8'(MAX_LEN))) begin
            err_len_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            wr_idx_d = '0;
            state_d  = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (rx_valid) begin
          payload_d[wr_idx_q] = rx_byte;
          csum_d              = csum_q + rx_byte;
          wr_idx_d            = wr_idx_q + IDX_W'(1);
          if (8'(wr_idx_q) == (len_q - 8'd1)) begin
            state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (rx_valid) begin
          if (rx_byte == csum_q) begin
            rd_idx_d    = '0;
            frame_len_d = len_q;
            state_d     = ST_HOLD;
          end else begin
            err_csum_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        overrun_d = rx_valid;
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            state_d = ST_IDLE;
          end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A byte arriving on the expiry cycle wins over the timeout
    if (in_frame && !rx_valid && (tmo_q == 16'(TIMEOUT))) begin
      err_timeout_d = 1'b1;
      state_d       = ST_IDLE;
    end

    out_valid_d = (state_d == ST_HOLD);
    out_data_d  = out_valid_d ? payload_q[rd_idx_d] : 8'd0;
    out_last_d  = out_valid_d && (8'(rd_idx_d) == (len_q - 8'd1));
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      len_q         <= 8'd0;
      csum_q        <= 8'd0;
      wr_idx_q      <= '0;
      rd_idx_q      <= '0;
      tmo_q         <= 16'd0;
      out_data_q    <= 8'd0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      frame_len_q   <= 8'd0;
      err_csum_q    <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      csum_q        <= csum_d;
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      tmo_q         <= tmo_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      frame_len_q   <= frame_len_d;
      err_csum_q    <= err_csum_d;
      err_len_q     <= err_len_d;
      err_timeout_q <= err_timeout_d;
      overrun_q     <= overrun_d;
      busy_q        <= busy_d;
    end
  end

  // Payload storage has no reset; contents are only read after being written
  always_ff @(posedge clk) begin
    payload_q <= payload_d;
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign frame_len   = frame_len_q;
  assign err_csum    = err_csum_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_timeout_q;
  assign overrun     = overrun_q;
  assign busy        = busy_q;

`ifdef SPI_RX_FRAME_STATS_EN
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] bad_cnt_q, bad_cnt_d;

  // Saturating frame statistics
  always_comb begin
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if ((state_q != ST_HOLD) && (state_d == ST_HOLD) && (good_cnt_q != 16'hFFFF)) begin
      good_cnt_d = good_cnt_q + 16'd1;
    end
    if ((err_csum_d || err_len_d || err_timeout_d) && (bad_cnt_q != 16'hFFFF)) begin
      bad_cnt_d = bad_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt_q <= 16'd0;
      bad_cnt_q  <= 16'd0;
    end else begin
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign good_cnt = good_cnt_q;
  assign bad_cnt  = bad_cnt_q;
`endif

endmodule

// File: tb/tb_spi_rx_frame_parser.sv
// Testbench for spi_rx_frame_parser: directed frames from the test plan plus randomized frames
// checked against a byte-level frame model; stats ports checked when SPI_RX_FRAME_STATS_EN is defined.
module tb_spi_rx_frame_parser;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned TMO     = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_byte = 8'd0;
  logic       rx_valid = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
  logic [7:0] frame_len;
  logic       err_csum, err_len, err_timeout, overrun, busy;
`ifdef SPI_RX_FRAME_STATS_EN
  logic [15:0] good_cnt, bad_cnt;
`endif

  spi_rx_frame_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT(TMO), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .frame_len(frame_len), .err_csum(err_csum), .err_len(err_len), .err_timeout(err_timeout),
    .overrun(overrun), .busy(busy)
`ifdef SPI_RX_FRAME_STATS_EN
    , .good_cnt(good_cnt), .bad_cnt(bad_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Observation side: record transfers and count pulse cycles
  logic [7:0] got_d[$];
  logic       got_l[$];
  logic [7:0] got_fl[$];
  int         got_c[$];
  int cyc = 0, n_csum = 0, n_len = 0, n_tmo = 0, n_ovr = 0, n_multi = 0;

  always @(negedge clk) begin
    cyc++;
    if (out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_l.push_back(out_last);
      got_fl.push_back(frame_len);
      got_c.push_back(cyc);
    end
    if (err_csum)    n_csum++;
    if (err_len)     n_len++;
    if (err_timeout) n_tmo++;
    if (overrun)     n_ovr++;
    if ((int'(err_csum) + int'(err_len) + int'(err_timeout)) > 1) n_multi++;
  end

  int total = 0, bad = 0;
  int gp = 0;
  bit rand_rdy = 1'b0;
  logic [7:0] seq[$];
  logic [7:0] pl[$];
  logic [7:0] exp_d[$];
  logic       exp_l[$];
  logic [7:0] exp_fl[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_byte  = 8'd0;
  endtask

  task automatic send_seq(input int unsigned maxgap);
    foreach (seq[i]) begin
      send(seq[i]);
      repeat ($urandom_range(0, maxgap)) tick();
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || out_valid) && n < 400) begin
      tick();
      n++;
    end
    chk(tag, {busy, out_valid}, 2'b00);
  endtask

  // Reference: a good frame yields its payload in order, last flag on the final byte
  task automatic expect_payload();
    for (int i = 0; i < pl.size(); i++) begin
      exp_d.push_back(pl[i]);
      exp_l.push_back(i == pl.size() - 1);
      exp_fl.push_back(8'(pl.size()));
    end
  endtask

  function automatic logic [7:0] model_csum(input logic [7:0] len);
    int s = int'(len);
    foreach (pl[i]) s += int'(pl[i]);
    return 8'(s % 256);
  endfunction

  task automatic check_drain(input string tag);
    int n = got_d.size() - gp;
    chk({tag, "_count"}, n, exp_d.size());
    for (int i = 0; i < n && i < exp_d.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), got_d[gp+i], exp_d[i]);
      chk($sformatf("%s_last%0d", tag, i), got_l[gp+i], exp_l[i]);
      chk($sformatf("%s_len%0d", tag, i), got_fl[gp+i], exp_fl[i]);
    end
    gp = got_d.size();
    exp_d.delete();
    exp_l.delete();
    exp_fl.delete();
  endtask

  initial begin
    int b_csum, b_len, b_tmo, b_ovr, span, e_csum, e_len;
    logic [7:0] ln, cs;

    // Reset state
    repeat (3) tick();
    chk("reset_outs", {out_data, out_valid, out_last, frame_len, err_csum, err_len,
                       err_timeout, overrun, busy}, 0);
`ifdef SPI_RX_FRAME_STATS_EN
    chk("reset_stats", {good_cnt, bad_cnt}, 0);
`endif
    rst_n = 1'b1;
    tick();

    // Good frame, back-to-back bytes, one-cycle latency
    b_csum = n_csum; b_len = n_len; b_tmo = n_tmo; b_ovr = n_ovr;
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    pl  = '{8'h11, 8'h22, 8'h33};
    expect_payload();
    send_seq(0);
    chk("good_first_valid", out_valid, 1'b1);
    chk("good_first_data", out_data, 8'h11);
    chk("good_frame_len", frame_len, 8'd3);
    wait_idle("good_idle");
    span = (got_c.size() >= gp + 3) ? (got_c[gp+2] - got_c[gp]) : -1;
    chk("good_consecutive", span, 2);
    check_drain("good");
    chk("good_noerr", (n_csum - b_csum) + (n_len - b_len) + (n_tmo - b_tmo) + (n_ovr - b_ovr), 0);

    // Bad checksum
    b_csum = n_csum;
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68};
    send_seq(0);
    tick();
    chk("badcs_pulse", n_csum - b_csum, 1);
    chk("badcs_busy", busy, 1'b0);
    check_drain("badcs");

    // Length errors and sync hunt
    b_len = n_len;
    seq = '{8'hA5, 8'h00};
    send_seq(0);
    tick();
    chk("len0_pulse", n_len - b_len, 1);
    seq = '{8'hA5, 8'h11};
    send_seq(0);
    tick();
    chk("len17_pulse", n_len - b_len, 2);
    seq = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    pl  = '{8'h7E};
    expect_payload();
    send_seq(0);
    wait_idle("hunt_idle");
    check_drain("hunt");
    chk("hunt_len_total", n_len - b_len, 2);

    // Inter-byte timeout, then recovery
    b_tmo = n_tmo;
    seq = '{8'hA5, 8'h02, 8'h44};
    send_seq(0);
    repeat (TMO - 2) tick();
    chk("tmo_not_early", {busy, 8'(n_tmo - b_tmo)}, {1'b1, 8'd0});
    repeat (8) tick();
    chk("tmo_pulse", n_tmo - b_tmo, 1);
    chk("tmo_busy", busy, 1'b0);
    seq = '{8'hA5, 8'h01, 8'h55, 8'h56};
    pl  = '{8'h55};
    expect_payload();
    send_seq(0);
    wait_idle("tmo_rec_idle");
    check_drain("tmo_rec");

    // Backpressure and overrun
    b_ovr = n_ovr;
    out_ready = 1'b0;
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    pl  = '{8'h11, 8'h22, 8'h33};
    expect_payload();
    send_seq(0);
    tick(); tick();
    chk("bp_hold_data", {out_valid, out_data}, {1'b1, 8'h11});
    send(8'h5A);
    tick();
    chk("bp_ovr_pulse", n_ovr - b_ovr, 1);
    chk("bp_after_ovr", {out_valid, out_data, busy}, {1'b1, 8'h11, 1'b1});
    out_ready = 1'b1;
    wait_idle("bp_idle");
    check_drain("bp");

    // Randomized frames with random gaps and random backpressure
    b_csum = n_csum; b_len = n_len; b_tmo = n_tmo; b_ovr = n_ovr;
    e_csum = 0; e_len = 0;
    rand_rdy = 1'b1;
    for (int u = 0; u < 40; u++) begin
      int k = int'($urandom_range(0, 9));
      seq.delete();
      pl.delete();
      if (k <= 6) begin
        ln = 8'($urandom_range(1, MAX_LEN));
        for (int i = 0; i < int'(ln); i++) pl.push_back(8'($urandom));
        cs = model_csum(ln);
        if (k >= 5) begin
          cs = cs + 8'($urandom_range(1, 255));
          e_csum++;
        end else begin
          expect_payload();
        end
        seq.push_back(8'hA5);
        seq.push_back(ln);
        foreach (pl[i]) seq.push_back(pl[i]);
        seq.push_back(cs);
      end else if (k == 7) begin
        ln = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255));
        seq = '{8'hA5, ln};
        e_len++;
      end else begin
        ln = 8'($urandom_range(0, 254));
        if (ln >= 8'hA5) ln = ln + 8'd1;
        seq.push_back(ln);
      end
      send_seq(3);
      tick();
      wait_idle($sformatf("rand_idle%0d", u));
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    tick();
    check_drain("rand");
    chk("rand_csum_errs", n_csum - b_csum, e_csum);
    chk("rand_len_errs", n_len - b_len, e_len);
    chk("rand_no_tmo_ovr", (n_tmo - b_tmo) + (n_ovr - b_ovr), 0);
    chk("err_exclusive", n_multi, 0);

    // Asynchronous reset in the middle of a frame
    seq = '{8'hA5, 8'h03, 8'h11};
    send_seq(0);
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outs", {out_data, out_valid, out_last, frame_len, err_csum, err_len,
                        err_timeout, overrun, busy}, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    b_csum = n_csum; b_len = n_len; b_tmo = n_tmo; b_ovr = n_ovr;
    seq = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    pl  = '{8'h7E};
    expect_payload();
    send_seq(0);
    wait_idle("post_rst_idle");
    check_drain("post_rst");
    chk("post_rst_noerr", (n_csum - b_csum) + (n_len - b_len) + (n_tmo - b_tmo) + (n_ovr - b_ovr), 0);
`ifdef SPI_RX_FRAME_STATS_EN
    chk("stats_good", good_cnt, 16'd1);
    chk("stats_bad", bad_cnt, 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
